// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bus bundle between the fetch/data requesters, the arbiter and the unified memory
// Signals: if_* fetch handshake, dm_* load/store handshake, mem_* memory port, stall to PC, err sticky timeout
// Modports: slave = arbiter view, master = requesters/memory view
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall;
  logic              err;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, stall, err
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port memory between instruction fetch and load/store
// Ports: clk, reset (async active-high), bus (mem_port_arbiter_if.slave: fetch, data, memory, stall, err)
// Optional: define ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles without mem_ready (ack with rdata 0, sticky err)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;
  state_t            state, state_n;
  logic              last_dm, last_dm_n;
  logic              mem_en_n, mem_we_n, if_ack_n, dm_ack_n, err_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, dm_rdata_n, rd;
  logic              if_ok, dm_ok, pick_dm, expire, done;
  // a side whose ack is high this cycle is dropping its request and must not be re-granted
  assign if_ok   = bus.if_req & ~bus.if_ack;
  assign dm_ok   = bus.dm_req & ~bus.dm_ack;
  assign pick_dm = dm_ok & (~if_ok | ~last_dm);
  assign bus.stall = if_ok | dm_ok;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = (state != IDLE) & ~bus.mem_ready & (cnt == 8'(TIMEOUT - 1));
  // held at zero in IDLE so every WAIT starts counting from zero
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (state == IDLE) ? '0 : cnt + 8'd1;
`else
  assign expire = 1'b0;
`endif
  assign done = bus.mem_ready | expire;
  assign rd   = expire ? '0 : bus.mem_rdata;
  always_comb begin
    state_n     = state;
    last_dm_n   = last_dm;
    mem_en_n    = bus.mem_en;
    mem_we_n    = bus.mem_we;
    mem_addr_n  = bus.mem_addr;
    mem_wdata_n = bus.mem_wdata;
    if_rdata_n  = bus.if_rdata;
    dm_rdata_n  = bus.dm_rdata;
    if_ack_n    = 1'b0;
    dm_ack_n    = 1'b0;
    err_n       = bus.err | expire;
    if (state == IDLE) begin
      if (if_ok | dm_ok) begin
        state_n     = pick_dm ? DM_WAIT : IF_WAIT;
        last_dm_n   = pick_dm;
        mem_en_n    = 1'b1;
        mem_we_n    = pick_dm & bus.dm_we;
        mem_addr_n  = pick_dm ? bus.dm_addr : bus.if_addr;
        mem_wdata_n = pick_dm ? bus.dm_wdata : '0;
      end
    end else if (done) begin
      state_n    = IDLE;
      mem_en_n   = 1'b0;
      mem_we_n   = 1'b0;
      if_ack_n   = state == IF_WAIT;
      dm_ack_n   = state == DM_WAIT;
      if_rdata_n = (state == IF_WAIT) ? rd : bus.if_rdata;
      dm_rdata_n = (state == DM_WAIT) ? rd : bus.dm_rdata;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      last_dm       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_n;
      last_dm       <= last_dm_n;
      bus.mem_en    <= mem_en_n;
      bus.mem_we    <= mem_we_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_wdata <= mem_wdata_n;
      bus.if_rdata  <= if_rdata_n;
      bus.dm_rdata  <= dm_rdata_n;
      bus.if_ack    <= if_ack_n;
      bus.dm_ack    <= dm_ack_n;
      bus.err       <= err_n;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a variable-latency memory model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic is_dm; logic we; logic [31:0] addr; logic [31:0] wdata;} grant_t;
  typedef struct {logic [31:0] rdata; logic chk_data; logic to; int lat;} ack_t;
  grant_t gq[$];
  ack_t   iq[$], dq[$];
  grant_t g;
  ack_t   a;
  int errors = 0, checks = 0, cyc = 0, lat = 0, wcnt = 0;
  int gcyc[2];
  int if_ack_cyc = 0, dm_ack_cyc = 0;
  logic p_en, p_ready, p_if_ack, p_dm_ack, p_we;
  logic [31:0] p_addr, p_wdata, keep_rd;
  function automatic logic [31:0] rd(logic [31:0] ad);
    return (ad == 32'h4) ? 32'h00500093 : ad * 3 + 32'h1000_0000;
  endfunction
  // memory model: ready after lat idle WAIT cycles, read data is a function of the address
  assign bus.mem_ready = bus.mem_en && (wcnt >= lat);
  assign bus.mem_rdata = rd(bus.mem_addr);
  always @(posedge clk) wcnt <= (bus.mem_en && !bus.mem_ready) ? wcnt + 1 : 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void expect_acc(logic dm, logic we, logic [31:0] ad, logic [31:0] wd, int l, logic to);
    ack_t e;
    gq.push_back('{dm, we, ad, wd});
    e = '{to ? 32'h0 : rd(ad), !we, to, to ? 8 : l + 1};
    if (dm) dq.push_back(e);
    else iq.push_back(e);
  endfunction
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      p_en = 0; p_ready = 0; p_if_ack = 0; p_dm_ack = 0;
    end else begin
      if (bus.mem_en && !p_en) begin
        if (gq.size() == 0) chk("grant_extra", 1, 0);
        else begin
          g = gq.pop_front();
          chk("grant_addr", bus.mem_addr, g.addr);
          chk("grant_we", bus.mem_we, g.we);
          chk("grant_wdata", bus.mem_wdata, g.wdata);
          gcyc[g.is_dm] = cyc;
        end
      end
      if (bus.mem_en && p_en) begin
        chk("hold_addr", bus.mem_addr, p_addr);
        chk("hold_we", bus.mem_we, p_we);
        chk("hold_wdata", bus.mem_wdata, p_wdata);
      end
      if (bus.if_ack) begin
        chk("if_ack_1cyc", p_if_ack, 0);
        if (iq.size() == 0) chk("if_ack_extra", 1, 0);
        else begin
          a = iq.pop_front();
          chk("if_rdata", bus.if_rdata, a.rdata);
          chk("if_lat", cyc - gcyc[0], a.lat);
          chk("if_ready_prev", p_ready, !a.to);
        end
        if_ack_cyc = cyc;
      end
      if (bus.dm_ack) begin
        chk("dm_ack_1cyc", p_dm_ack, 0);
        if (dq.size() == 0) chk("dm_ack_extra", 1, 0);
        else begin
          a = dq.pop_front();
          if (a.chk_data) chk("dm_rdata", bus.dm_rdata, a.rdata);
          chk("dm_lat", cyc - gcyc[1], a.lat);
          chk("dm_ready_prev", p_ready, !a.to);
        end
        dm_ack_cyc = cyc;
      end
      p_en = bus.mem_en; p_ready = bus.mem_ready; p_if_ack = bus.if_ack; p_dm_ack = bus.dm_ack;
      p_addr = bus.mem_addr; p_we = bus.mem_we; p_wdata = bus.mem_wdata;
    end
  end
  task automatic fetch(input logic [31:0] ad, input bit keep);
    bus.if_addr = ad;
    bus.if_req  = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (bus.if_ack) begin
        if (!keep) bus.if_req = 0;
        return;
      end
    end
    chk("if_ack_timeout", 0, 1);
    bus.if_req = 0;
  endtask
  task automatic data(input logic we, input logic [31:0] ad, input logic [31:0] wd, input bit keep);
    bus.dm_we    = we;
    bus.dm_addr  = ad;
    bus.dm_wdata = wd;
    bus.dm_req   = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (bus.dm_ack) begin
        if (!keep) bus.dm_req = 0;
        return;
      end
    end
    chk("dm_ack_timeout", 0, 1);
    bus.dm_req = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_if_ack", bus.if_ack, 0);
    chk("rst_dm_ack", bus.dm_ack, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_stall", bus.stall, 0);
    reset = 0;
    @(posedge clk); #2;
    expect_acc(0, 0, 32'h4, 0, 0, 0);
    bus.if_addr = 32'h4;
    bus.if_req  = 1;
    #1 chk("f_stall_req", bus.stall, 1);
    @(posedge clk); #2;
    chk("f_mem_en", bus.mem_en, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h4);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_no_ack_yet", bus.if_ack, 0);
    chk("f_stall_wait", bus.stall, 1);
    @(posedge clk); #2;
    chk("f_ack", bus.if_ack, 1);
    chk("f_rdata", bus.if_rdata, 32'h00500093);
    chk("f_stall_ack", bus.stall, 0);
    bus.if_req = 0;
    @(posedge clk); #2;
    chk("f_ack_drop", bus.if_ack, 0);
    chk("f_rdata_keep", bus.if_rdata, 32'h00500093);
    chk("f_mem_en_drop", bus.mem_en, 0);
    expect_acc(1, 0, 32'h100, 0, 0, 0);
    expect_acc(0, 0, 32'h8, 0, 0, 0);
    fork
      data(0, 32'h100, 0, 0);
      fetch(32'h8, 0);
    join
    chk("tie_dm_first", dm_ack_cyc < if_ack_cyc, 1);
    for (int i = 0; i < 3; i++) begin
      expect_acc(1, 0, 32'h200 + 4 * i, 32'h55 + i, 0, 0);
      expect_acc(0, 0, 32'h40 + 4 * i, 0, 0, 0);
    end
    fork
      for (int i = 0; i < 3; i++) data(0, 32'h200 + 4 * i, 32'h55 + i, i < 2);
      for (int j = 0; j < 3; j++) fetch(32'h40 + 4 * j, j < 2);
    join
    @(posedge clk); #2;
    lat = 3;
    expect_acc(1, 1, 32'h20, 32'hCAFEF00D, 3, 0);
    data(1, 32'h20, 32'hCAFEF00D, 0);
    lat = 0;
    @(posedge clk); #2;
    lat = 1000;
    gq.push_back('{1'b1, 1'b0, 32'h300, 32'h0});
    bus.dm_we = 0; bus.dm_addr = 32'h300; bus.dm_wdata = 0; bus.dm_req = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("r_in_wait", bus.mem_en, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("r_mem_en_async", bus.mem_en, 0);
    chk("r_no_dm_ack", bus.dm_ack, 0);
    bus.dm_req = 0;
    @(posedge clk); #2;
    chk("r_no_dm_ack_hold", bus.dm_ack, 0);
    @(negedge clk);
    reset = 0;
    lat = 0;
    expect_acc(0, 0, 32'h44, 0, 0, 0);
    fetch(32'h44, 0);
`ifdef ARB_TIMEOUT_EN
    @(posedge clk); #2;
    lat = 1000;
    expect_acc(0, 0, 32'h80, 0, 0, 1);
    fetch(32'h80, 0);
    chk("t_err_set", bus.err, 1);
    lat = 0;
    expect_acc(0, 0, 32'h84, 0, 0, 0);
    fetch(32'h84, 0);
    @(posedge clk); #2;
    chk("t_err_sticky", bus.err, 1);
`else
    chk("err_zero", bus.err, 0);
`endif
    repeat (2) @(posedge clk);
    #2;
    chk("left_grants", gq.size(), 0);
    chk("left_if_acks", iq.size(), 0);
    chk("left_dm_acks", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
